// File: rtl/dmem_store_buffer_pkg.sv
// dmem_store_buffer_pkg: shared entry type and address width for the data-memory store buffer
package dmem_store_buffer_pkg;

    localparam int SB_ADDR_W = 30;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [31:0]          wd;
        logic [3:0]           mask;
    } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_sb_fifo.sv
// dmem_store_buffer_sb_fifo: register FIFO of pending stores with a parallel word-address hit compare
module dmem_store_buffer_sb_fifo
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  sb_entry_t            push_entry,
    input  logic                 pop,
    input  logic [SB_ADDR_W-1:0] query_addr,
    output logic                 full,
    output logic                 empty,
    output sb_entry_t            head,
    output logic                 hit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        mem_q [DEPTH];
    sb_entry_t        mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign head  = mem_q[head_q];

    // Next-state: pop frees the head slot, push fills the tail slot; both may happen together
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (push) begin
            mem_d[tail_q]   = push_entry;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Any valid entry holding the queried word is a hit
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            hit = hit | (valid_q[i] && mem_q[i].addr == query_addr);
    end

    // FIFO state registers; reset discards every pending store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write store buffer arbitrating the L1 data port between loads and drains
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int LOAD_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wd,
    input  logic [3:0]  core_mask,
    output logic [31:0] core_rd,
    output logic        core_wait,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rd,
    input  logic        mem_wait,
    output logic        sb_empty
);

    localparam int SW = $clog2(LOAD_STREAK + 1);

    logic          load, store, full, empty, hit, blocked, load_owns, drain, push, pop;
    sb_entry_t     head, push_entry;
    logic [SW-1:0] streak_q, streak_d;

    assign push_entry = '{addr: core_addr[31:2], wd: core_wd, mask: core_mask};

    dmem_store_buffer_sb_fifo #(.DEPTH(DEPTH)) u_sb_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .query_addr (core_addr[31:2]),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .hit        (hit)
    );

    // Port arbitration and output muxing: a missing load owns the port unless its streak is exhausted
    always_comb begin
        load      = core_req && !core_we;
        store     = core_req && core_we;
        blocked   = streak_q == SW'(LOAD_STREAK) && !empty;
        load_owns = load && !hit && !blocked;
        drain     = !load_owns && !empty;
        push      = store && !full;
        pop       = drain && !mem_wait;
        mem_req   = load_owns || drain;
        mem_we    = drain;
        mem_addr  = load_owns ? core_addr : drain ? {head.addr, 2'b00} : '0;
        mem_wd    = drain ? head.wd : '0;
        mem_mask  = drain ? head.mask : '0;
        core_rd   = load_owns ? mem_rd : '0;
        core_wait = store ? full : load ? (load_owns ? mem_wait : 1'b1) : 1'b0;
        sb_empty  = empty;
    end

    // Streak counts load-owned cycles while stores wait; any drain or an empty buffer clears it
    always_comb begin
        streak_d = streak_q;
        if (empty || drain)
            streak_d = '0;
        else if (load_owns && streak_q != SW'(LOAD_STREAK))
            streak_d = streak_q + SW'(1);
    end

    // Streak register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) streak_q <= '0;
        else        streak_q <= streak_d;
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed and random checks of the store buffer against a flat in-order memory model
module tb_dmem_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wd;
    logic [3:0]  core_mask;
    logic [31:0] core_rd;
    logic        core_wait;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wd;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rd;
    logic        mem_wait;
    logic        sb_empty;

    logic        mw, rnd_wait, rw;
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    assign mem_rd   = mem[mem_addr[11:2]];
    assign mem_wait = rnd_wait ? rw : mw;

    dmem_store_buffer #(.DEPTH(4), .LOAD_STREAK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .core_req  (core_req),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wd   (core_wd),
        .core_mask (core_mask),
        .core_rd   (core_rd),
        .core_wait (core_wait),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_mask  (mem_mask),
        .mem_rd    (mem_rd),
        .mem_wait  (mem_wait),
        .sb_empty  (sb_empty)
    );

    // Cache model: byte-masked writes on accepted drains, random busy generator
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (mem_req && mem_we && !mem_wait) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wd[8*b +: 8];
        end
        rw <= rnd_wait && ($urandom_range(0, 7) == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wd = '0; core_mask = '0;
    endtask

    // Drive one access, hold it until accepted, update the reference / check the load via the scoreboard
    task automatic op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      output int waits);
        core_req = 1'b1; core_we = we; core_addr = a; core_wd = d; core_mask = m;
        if (!we) exp_q.push_back(ref_mem[a[11:2]]);
        waits = 0;
        @(negedge clk);
        while (core_wait && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        check("accept_timeout", {31'd0, core_wait}, 32'd0);
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
        end else begin
            check("load_data", core_rd, exp_q.pop_front());
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_empty();
        int n = 0;
        @(negedge clk);
        while (!sb_empty && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain_done", {31'd0, sb_empty}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        int r;
        logic [31:0] a;
        rst_n = 1'b0; mw = 1'b0; rnd_wait = 1'b0;
        idle();
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_core_wait", {31'd0, core_wait}, 32'd0);
        check("rst_core_rd", core_rd, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single store retires immediately and drains the following cycle
        op(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, w);
        check("st_zero_wait", w, 0);
        idle();
        @(negedge clk);
        check("drain_req", {31'd0, mem_req}, 32'd1);
        check("drain_we", {31'd0, mem_we}, 32'd1);
        check("drain_addr", mem_addr, 32'h100);
        check("drain_wd", mem_wd, 32'hDEADBEEF);
        check("drain_mask", {28'd0, mem_mask}, 32'hF);
        @(posedge clk); #1;
        @(negedge clk);
        check("st_empty_after", {31'd0, sb_empty}, 32'd1);
        check("st_mem_word", mem[32'h40], 32'hDEADBEEF);
        check("idle_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;

        // Fill the buffer against a stalled cache; the fifth store waits for a slot
        mw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 32'h500 + 32'(4 * i), 32'h11110000 + 32'(i), 4'hF, w);
            check("fill_wait", w, 0);
        end
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h510; core_wd = 32'h55555555; core_mask = 4'hF;
        repeat (3) begin
            @(negedge clk);
            check("full_wait", {31'd0, core_wait}, 32'd1);
        end
        @(posedge clk); #1;
        mw = 1'b0;
        @(negedge clk);
        check("pop_no_free", {31'd0, core_wait}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("fifth_accept", {31'd0, core_wait}, 32'd0);
        ref_mem[32'h510 >> 2] = 32'h55555555;
        @(posedge clk); #1;
        idle();
        wait_empty();

        // Load hitting a buffered byte stalls until it drains, then sees the stored byte
        op(1'b1, 32'h200, 32'h000000AB, 4'h1, w);
        op(1'b0, 32'h203, 32'h0, 4'h0, w);
        check("hit_stall_cycles", w, 1);

        // Load streak: four loads own the port, the fifth cycle is given to the drain
        op(1'b1, 32'h300, 32'hC0FFEE00, 4'hF, w);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h400; core_wd = '0; core_mask = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("streak_wait%0d", k), {31'd0, core_wait}, (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("streak_we%0d", k), {31'd0, mem_we}, (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("streak_addr%0d", k), mem_addr, (k == 4) ? 32'h300 : 32'h400);
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        check("streak_empty", {31'd0, sb_empty}, 32'd1);
        @(posedge clk); #1;

        // Random mixed traffic against a randomly busy cache
        rnd_wait = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15)) << 2;
            if (r < 4)
                op(1'b1, a, $urandom, 4'($urandom_range(0, 15)), w);
            else if (r < 8)
                op(1'b0, a | 32'($urandom_range(0, 3)), 32'h0, 4'h0, w);
            else begin
                idle();
                @(posedge clk); #1;
            end
        end
        idle();
        rnd_wait = 1'b0;
        wait_empty();
        for (int i = 0; i < 1024; i++) check($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

        // Asynchronous reset mid-drain discards pending stores at once
        mw = 1'b1;
        op(1'b1, 32'h600, 32'h12345678, 4'hF, w);
        op(1'b1, 32'h604, 32'h9ABCDEF0, 4'hF, w);
        idle();
        @(negedge clk);
        check("middrain_req", {31'd0, mem_req}, 32'd1);
        check("middrain_addr", mem_addr, 32'h600);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_empty", {31'd0, sb_empty}, 32'd1);
        check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mw = 1'b0;
        @(negedge clk);
        check("post_rst_empty", {31'd0, sb_empty}, 32'd1);
        check("post_rst_mem_req", {31'd0, mem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
